// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate sequencer around an external 4-bit one-hot-controlled shifter.
// Iterates the shifter once per clock in RUN and holds the final value in result_out.
module shift_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_out,
   output logic [WIDTH-1:0] sh_data,
   output logic [3:0]       sh_ctrl,
   input  logic [WIDTH-1:0] sh_result
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         op_q     <= 2'b00;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      busy     = 1'b0;
      done     = 1'b0;
      sh_ctrl  = 4'b0001;
      unique case (state_q)
         StIdle, StDone: begin
            done = (state_q == StDone);
            if (start) begin
               acc_d = data_in;
               op_d  = op;
               cnt_d = amount;
               // Nothing to iterate: finish immediately with the operand itself.
               if (amount == '0 || op == 2'b00) begin
                  state_d  = StDone;
                  result_d = data_in;
               end else begin
                  state_d = StRun;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            busy    = 1'b1;
            sh_ctrl = 4'b0001 << op_q;
            acc_d   = sh_result;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d  = StDone;
               result_d = sh_result;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign sh_data    = acc_q;
   assign result_out = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: reference shifter, queue-based schedule model checked every
// cycle, plus directed operations with literal expected results.
module tb_shift_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [2:0] amount;
   logic [3:0] data_in;
   logic       busy;
   logic       done;
   logic [3:0] result_out;
   logic [3:0] sh_data;
   logic [3:0] sh_ctrl;
   logic [3:0] sh_result;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op         (op),
      .amount     (amount),
      .data_in    (data_in),
      .busy       (busy),
      .done       (done),
      .result_out (result_out),
      .sh_data    (sh_data),
      .sh_ctrl    (sh_ctrl),
      .sh_result  (sh_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference shifter {A,B,C,D} x {i,j,k,l} -> {W,X,Y,Z}
   always_comb begin
      case (sh_ctrl)
         4'b0001: sh_result = sh_data;
         4'b0010: sh_result = {sh_data[2:0], 1'b0};
         4'b0100: sh_result = {1'b0, sh_data[3:1]};
         4'b1000: sh_result = {sh_data[0], sh_data[3:1]};
         default: sh_result = 4'b0000;
      endcase
   end

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [3:0] data;
      logic [3:0] ctrl;
      logic [3:0] result;
   } exp_t;

   exp_t cur;
   exp_t sched[$];

   function automatic logic [3:0] step(input logic [3:0] d, input logic [1:0] o);
      int v;
      v = int'(d);
      case (o)
         2'd1:    v = (v * 2) % 16;
         2'd2:    v = v / 2;
         2'd3:    v = v / 2 + (v % 2) * 8;
         default: v = v;
      endcase
      return 4'(v);
   endfunction

   function automatic logic [3:0] ctrl_of(input logic [1:0] o);
      case (o)
         2'd1:    return 4'b0010;
         2'd2:    return 4'b0100;
         2'd3:    return 4'b1000;
         default: return 4'b0001;
      endcase
   endfunction

   // Model: an accepted op expands into a per-cycle schedule of expected outputs.
   always @(posedge clk) begin
      int         k;
      logic [3:0] v;
      if (rst) begin
         sched.delete();
         cur = '{busy: 1'b0, done: 1'b0, data: 4'h0, ctrl: 4'b0001, result: 4'h0};
      end else if (sched.size() != 0) begin
         cur = sched.pop_front();
      end else if (start) begin
         k = (op == 2'b00) ? 0 : int'(amount);
         v = data_in;
         for (int i = 0; i < k; i++) begin
            sched.push_back('{busy: 1'b1, done: 1'b0, data: v, ctrl: ctrl_of(op),
                              result: cur.result});
            v = step(v, op);
         end
         sched.push_back('{busy: 1'b0, done: 1'b1, data: v, ctrl: 4'b0001, result: v});
         cur = sched.pop_front();
      end else begin
         cur.busy = 1'b0;
         cur.done = 1'b0;
         cur.ctrl = 4'b0001;
      end
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start_op(input logic [3:0] d, input logic [1:0] o, input logic [2:0] a);
      start   = 1'b1;
      data_in = d;
      op      = o;
      amount  = a;
      @(negedge clk);
      start   = 1'b0;
      data_in = 4'($urandom);
      op      = 2'($urandom);
      amount  = 3'($urandom);
   endtask

   task automatic wait_done(output int nbusy, output bit seen);
      nbusy = 0;
      seen  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic run(input string name, input logic [3:0] d, input logic [1:0] o,
                      input logic [2:0] a, input logic [3:0] exp_res, input int exp_busy);
      int nb;
      bit seen;
      start_op(d, o, a);
      wait_done(nb, seen);
      check({name, "_done_seen"}, 4'(seen), 4'd1);
      check({name, "_busy_cycles"}, 4'(nb), 4'(exp_busy));
      check({name, "_result"}, result_out, exp_res);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_busy"}, 4'(busy), 4'd0);
      check({name, "_done"}, 4'(done), 4'd0);
      check({name, "_result"}, result_out, 4'b0000);
      check({name, "_sh_data"}, sh_data, 4'b0000);
      check({name, "_sh_ctrl"}, sh_ctrl, 4'b0001);
   endtask

   initial begin
      int nb;
      bit seen;
      int dn;

      rst     = 1'b1;
      start   = 1'b0;
      op      = 2'b00;
      amount  = 3'd0;
      data_in = 4'h0;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               check("cyc_busy", 4'(busy), 4'(cur.busy));
               check("cyc_done", 4'(done), 4'(cur.done));
               check("cyc_sh_data", sh_data, cur.data);
               check("cyc_sh_ctrl", sh_ctrl, cur.ctrl);
               check("cyc_result", result_out, cur.result);
            end
         end
         begin
            #200000;
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
         end
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      chk_en = 1'b1;
      rst    = 1'b0;
      @(negedge clk);

      // T1 / T2
      run("t1_shl", 4'b1011, 2'b01, 3'd2, 4'b1100, 2);
      @(negedge clk);
      run("t2_shr", 4'b1011, 2'b10, 3'd1, 4'b0101, 1);
      @(negedge clk);

      // T3: rotate with visible shifter operands
      start_op(4'b1000, 2'b11, 3'd3);
      check("t3_data0", sh_data, 4'b1000);
      check("t3_ctrl0", sh_ctrl, 4'b1000);
      check("t3_busy0", 4'(busy), 4'd1);
      @(negedge clk);
      check("t3_data1", sh_data, 4'b0100);
      check("t3_busy1", 4'(busy), 4'd1);
      @(negedge clk);
      check("t3_data2", sh_data, 4'b0010);
      check("t3_busy2", 4'(busy), 4'd1);
      @(negedge clk);
      wait_done(nb, seen);
      check("t3_done_seen", 4'(seen), 4'd1);
      check("t3_extra_busy", 4'(nb), 4'd0);
      check("t3_result", result_out, 4'b0001);
      @(negedge clk);

      // T4: zero amount and pass op
      run("t4_zero", 4'b0110, 2'b01, 3'd0, 4'b0110, 0);
      @(negedge clk);
      run("t4_pass", 4'b1001, 2'b00, 3'd5, 4'b1001, 0);
      @(negedge clk);

      // T5: start during RUN ignored, start in DONE accepted
      start_op(4'b0011, 2'b01, 3'd3);
      start   = 1'b1;
      data_in = 4'b1111;
      op      = 2'b10;
      amount  = 3'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(nb, seen);
      check("t5_first_seen", 4'(seen), 4'd1);
      check("t5_first_busy", 4'(nb), 4'd2);
      check("t5_first_result", result_out, 4'b1000);
      run("t5_second", 4'b1110, 2'b10, 3'd2, 4'b0011, 2);

      // T6: reset in the middle of a long rotate
      start_op(4'b1001, 2'b11, 3'd7);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("t6_after_rst");
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("t6_no_done", 4'(dn), 4'd0);
      run("t6_fresh", 4'b0001, 2'b01, 3'd3, 4'b1000, 3);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
